// File: rtl/muldiv_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit: single-cycle multiply, 32-step restoring divide.
// Results land in hi/lo with a one-cycle done/whilo strobe; stall holds the execute stage.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        stall,
    output logic        done,
    output logic        whilo,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t      state, state_nxt;
    logic [31:0] opa;        // multiplicand, or dividend magnitude that shifts into the quotient
    logic [31:0] opb;        // multiplier, or divisor magnitude
    logic [31:0] rem;
    logic [4:0]  cnt;
    logic        mul_signed, neg_q, neg_r, div_zero;

    logic        accept, div_signed, a_neg, b_neg, div_last;
    logic [32:0] partial;
    logic        q_bit;
    logic [31:0] rem_sub, rem_nxt, quo_nxt;
    logic [63:0] prod;

    // Handshake: a request is taken when start=1 and flush=0 in IDLE/DONE;
    // stall stays high from that cycle until the result cycle, so operands are held by the producer.
    always_comb begin
        accept     = ((state == S_IDLE) || (state == S_DONE)) && start && !flush;
        div_signed = (op == 2'b10);
        a_neg      = div_signed & a[31];
        b_neg      = div_signed & b[31];
        partial    = {rem, opa[31]};
        q_bit      = (partial >= {1'b0, opb});
        rem_sub    = partial[31:0] - opb;
        rem_nxt    = q_bit ? rem_sub : partial[31:0];
        quo_nxt    = {opa[30:0], q_bit};
        div_last   = (cnt == 5'd31);
        if (mul_signed)
            prod = {{32{opa[31]}}, opa} * {{32{opb[31]}}, opb};
        else
            prod = {32'b0, opa} * {32'b0, opb};
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: state_nxt = accept ? (op[1] ? S_DIV : S_MUL) : S_IDLE;
            S_MUL:          state_nxt = flush ? S_IDLE : S_DONE;
            S_DIV:          state_nxt = flush ? S_IDLE : (div_last ? S_DONE : S_DIV);
            default:        state_nxt = S_IDLE;
        endcase
        stall = (state == S_MUL) || (state == S_DIV) || accept;
        done  = (state == S_DONE);
        whilo = done;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            opa        <= '0;
            opb        <= '0;
            rem        <= '0;
            cnt        <= '0;
            mul_signed <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
            hi         <= '0;
            lo         <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                opa        <= a_neg ? -a : a;
                opb        <= b_neg ? -b : b;
                mul_signed <= ~op[0];
                neg_q      <= div_signed & (a[31] ^ b[31]);
                neg_r      <= a_neg;
                div_zero   <= (b == 32'd0);
                rem        <= '0;
                cnt        <= '0;
            end
            if (state == S_MUL && !flush) begin
                hi <= prod[63:32];
                lo <= prod[31:0];
            end
            if (state == S_DIV && !flush) begin
                rem <= rem_nxt;
                opa <= quo_nxt;
                cnt <= cnt + 5'd1;
                if (div_last) begin
                    // Divide-by-zero keeps the raw all-ones quotient; remainder fixup restores a.
                    lo <= (neg_q && !div_zero) ? -quo_nxt : quo_nxt;
                    hi <= neg_r ? -rem_nxt : rem_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: driver tasks push expected {hi,lo} into a queue,
// a negedge monitor pops and compares on every done strobe.
module tb_muldiv_unit;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    logic        clk = 1'b0;
    logic        rst, start, flush;
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        stall, done, whilo;
    logic [31:0] hi, lo;

    int          checks = 0;
    int          failures = 0;
    logic [63:0] exp_q[$];
    logic [31:0] last_h, last_l;

    muldiv_unit dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .stall (stall),
        .done  (done),
        .whilo (whilo),
        .hi    (hi),
        .lo    (lo)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL global_timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    // ---------------- checking helper ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (!rst) begin
            check("whilo_eq_done", 64'(whilo), 64'(done));
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual hi=%h lo=%h required no strobe", hi, lo);
                end else begin
                    check("result_hilo", {hi, lo}, exp_q.pop_front());
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Call at a falling edge; returns at the falling edge of T1 with start dropped.
    task automatic send(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] h, input logic [31:0] l, input bit push);
        start = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        if (push) exp_q.push_back({h, l});
        #1;
        check("stall_t0", 64'(stall), 64'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Returns 1 time unit after the falling edge of the DONE cycle.
    task automatic wait_done(input int lat);
        int cyc;
        bit bad;
        cyc = 1;
        bad = 1'b0;
        forever begin
            #1;
            if (done) break;
            if (stall !== 1'b1) bad = 1'b1;
            if (cyc >= 60) break;
            @(negedge clk);
            cyc++;
        end
        check("busy_stall_low", 64'(bad), 64'd0);
        check("latency", 64'(cyc), 64'(lat));
        check("done_stall", 64'(stall), 64'd0);
    endtask

    task automatic run(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] h, input logic [31:0] l, input int lat);
        send(o, x, y, h, l, 1'b1);
        wait_done(lat);
        last_h = h;
        last_l = l;
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst   = 1'b1;
        start = 1'b0;
        flush = 1'b0;
        op    = 2'b00;
        a     = '0;
        b     = '0;
        last_h = '0;
        last_l = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_flags", {61'd0, stall, done, whilo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // multiply
        run(OP_MULTU, 32'hFFFFFFFF, 32'd2,        32'h00000001, 32'hFFFFFFFE, 2);
        run(OP_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 2);
        run(OP_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2);
        run(OP_MULTU, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 2);
        run(OP_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE, 2);

        // divide
        run(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 33);
        run(OP_DIVU, 32'd100,      32'd7,        32'd2,        32'd14,       33);
        run(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 33);
        run(OP_DIVU, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'd1,        32'd1,        33);
        run(OP_DIVU, 32'd100,      32'd0,        32'd100,      32'hFFFFFFFF, 33);
        run(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 33);

        // flush mid-divide at T10
        send(OP_DIVU, 32'd1000, 32'd3, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("flush_stall", 64'(stall), 64'd0);
        check("flush_done", 64'(done), 64'd0);
        check("flush_hilo_held", {hi, lo}, {last_h, last_l});
        repeat (40) @(negedge clk);
        check("flush_hilo_later", {hi, lo}, {last_h, last_l});

        // start together with flush is refused
        start = 1'b1;
        op    = OP_MULTU;
        a     = 32'd5;
        b     = 32'd6;
        flush = 1'b1;
        #1;
        check("sf_stall_t0", 64'(stall), 64'd0);
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
        #1;
        check("sf_stall_t1", 64'(stall), 64'd0);
        repeat (5) @(negedge clk);
        check("sf_hilo_held", {hi, lo}, {last_h, last_l});

        // back-to-back: second request issued in the DONE cycle of the first
        send(OP_MULTU, 32'd7, 32'd6, 32'd0, 32'd42, 1'b1);
        wait_done(2);
        check("b2b_done_first", 64'(done), 64'd1);
        send(OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b1);
        wait_done(33);
        last_h = 32'd2;
        last_l = 32'd14;
        @(negedge clk);

        // asynchronous reset mid-divide at T10
        send(OP_DIV, 32'd1000, 32'd7, 32'd0, 32'd0, 1'b0);
        repeat (9) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("arst_hilo", {hi, lo}, 64'd0);
        check("arst_flags", {61'd0, stall, done, whilo}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        last_h = '0;
        last_l = '0;
        @(negedge clk);
        run(OP_MULTU, 32'hFFFFFFFF, 32'd2, 32'h00000001, 32'hFFFFFFFE, 2);
        run(OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 33);

        repeat (3) @(negedge clk);
        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
